// File: rtl/lsm_transfer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_transfer_unit
//  Purpose  : Mask-driven load-multiple / store-multiple sequencer. Walks the
//             selected registers in ascending order and moves one word per
//             memory handshake between the register file and memory.
//             Unselected registers cost no cycles. Memory latency is absorbed
//             through a req/ack handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock for all state
//    reset       in   synchronous active-high reset; also gates strobes
//    start       in   one-cycle request, accepted only while idle
//    is_store    in   1 = store-multiple (reg->mem), 0 = load-multiple
//    mask        in   register select mask, bit i = register i
//    base_addr   in   first memory word address
//    busy        out  operation in flight (cycle after accept .. done)
//    done        out  one-cycle completion pulse
//    xfer_count  out  transfers completed in current / last operation
//    rf_raddr    out  register read index (store)
//    rf_rdata    in   combinational read data for rf_raddr
//    rf_waddr    out  register write index (load)
//    rf_wdata    out  register write data (load)
//    rf_wen      out  register write strobe (load)
//    mem_req     out  memory access request
//    mem_we      out  memory write enable, valid with mem_req
//    mem_addr    out  memory word address, valid with mem_req
//    mem_wdata   out  memory write data, valid with mem_req & mem_we
//    mem_ack     in   access complete; mem_rdata valid this cycle on reads
//    mem_rdata   in   memory read data
// ============================================================================
module lsm_transfer_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int NREG   = 8,
   parameter int REG_AW = $clog2(NREG),
   parameter int CNT_W  = $clog2(NREG + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [NREG-1:0]   mask,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  xfer_count,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_wen,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]        state;
   logic [NREG-1:0]   rem_mask;
   logic [ADDR_W-1:0] base;
   logic              store;

   logic [REG_AW-1:0] idx;
   logic [NREG-1:0]   rem_clr;
   logic              access;
   logic              in_sm;
   logic              in_lm;
   logic [ADDR_W-1:0] cur_addr;

   // ------------------------------------------------------------------------
   // Lowest set bit of the remaining mask. Scanning downwards lets the last
   // (lowest) hit win, giving ascending register order.
   // ------------------------------------------------------------------------
   always_comb begin
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (rem_mask[i]) begin
            idx = REG_AW'(i);
         end
      end
   end

   // x & (x-1) removes exactly the lowest set bit, i.e. bit idx.
   assign rem_clr = rem_mask & (rem_mask - NREG'(1));

   // The completed-transfer count doubles as the address offset k: both
   // clear on accept and advance together on every acknowledged access.
   assign cur_addr = base + ADDR_W'(xfer_count);

   assign access = (state == ACCESS);
   assign in_sm  = access &&  store;
   assign in_lm  = access && !store;

   // ------------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rem_mask   <= '0;
         base       <= '0;
         store      <= 1'b0;
         xfer_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rem_mask   <= mask;
                  base       <= base_addr;
                  store      <= is_store;
                  xfer_count <= '0;
                  state      <= (mask != '0) ? ACCESS : DONE;
               end
            end
            ACCESS: begin
               // mem_req is always high here, so any ack belongs to us.
               if (mem_ack) begin
                  rem_mask   <= rem_clr;
                  xfer_count <= xfer_count + CNT_W'(1);
                  if (rem_clr == '0) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Port outputs. Strobes are additionally masked by reset so that a reset
   // landing mid-operation never lets a partial access or write escape.
   // ------------------------------------------------------------------------
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE) && !reset;

      mem_req   = access && !reset;
      mem_we    = in_sm;
      mem_addr  = access ? cur_addr : '0;
      mem_wdata = in_sm  ? rf_rdata : '0;

      rf_raddr  = in_sm  ? idx : '0;
      rf_waddr  = in_lm  ? idx : '0;
      rf_wdata  = in_lm  ? mem_rdata : '0;
      rf_wen    = in_lm && mem_ack && !reset;
   end

endmodule
`default_nettype wire

// File: tb/tb_lsm_transfer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsm_transfer_unit
//  Purpose  : Directed self-checking bench for lsm_transfer_unit. Two
//             instances: default sizing (NREG=8, DATA_W=16) and a wide one
//             (NREG=16, DATA_W=32). Memory read data is address ^ 16'hA5A5
//             for the narrow instance and {16'hC0DE, address} for the wide
//             one; register read data is 16'h1000 + index.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsm_transfer_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- narrow instance ----------------
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [7:0]  mask = '0;
   logic [15:0] base_addr = '0;
   logic        busy, done;
   logic [3:0]  xfer_count;
   logic [2:0]  rf_raddr, rf_waddr;
   logic [15:0] rf_rdata, rf_wdata;
   logic        rf_wen;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic        delay_mode = 1'b0;
   logic        ack_force = 1'b0;
   int          wcnt = 0;

   assign rf_rdata  = 16'h1000 + {13'd0, rf_raddr};
   assign mem_rdata = mem_addr ^ 16'hA5A5;
   assign mem_ack   = ack_force | (mem_req & (delay_mode ? (wcnt == 3) : 1'b1));

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
   end

   lsm_transfer_unit dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .mask(mask), .base_addr(base_addr), .busy(busy), .done(done),
      .xfer_count(xfer_count), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // ---------------- wide instance ----------------
   logic        start16 = 1'b0;
   logic [15:0] mask16 = '0;
   logic [15:0] base16 = '0;
   logic        busy16, done16;
   logic [4:0]  xfer16;
   logic [3:0]  rf_raddr16, rf_waddr16;
   logic [31:0] rf_rdata16, rf_wdata16;
   logic        rf_wen16;
   logic        mem_req16, mem_we16, mem_ack16;
   logic [15:0] mem_addr16;
   logic [31:0] mem_wdata16, mem_rdata16;

   assign rf_rdata16  = {16'h2000, 12'd0, rf_raddr16};
   assign mem_rdata16 = {16'hC0DE, mem_addr16};
   assign mem_ack16   = mem_req16;

   lsm_transfer_unit #(.DATA_W(32), .ADDR_W(16), .NREG(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .is_store(1'b0),
      .mask(mask16), .base_addr(base16), .busy(busy16), .done(done16),
      .xfer_count(xfer16), .rf_raddr(rf_raddr16), .rf_rdata(rf_rdata16),
      .rf_waddr(rf_waddr16), .rf_wdata(rf_wdata16), .rf_wen(rf_wen16),
      .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
      .mem_wdata(mem_wdata16), .mem_ack(mem_ack16), .mem_rdata(mem_rdata16)
   );

   // ---------------- activity logs ----------------
   // Sampled 1 time unit after each rising edge; a sample taken after edge
   // e is labelled cycle e+1, matching "accept at t, first access in t+1".
   int rfw_addr[$], rfw_data[$], rfw_cyc[$];
   int memw_addr[$], memw_data[$];
   int done_cyc[$];
   int req_cnt = 0;
   int unstable = 0;
   logic        prev_wait = 1'b0;
   logic [15:0] prev_addr = '0;
   logic        prev_we = 1'b0;

   logic [31:0] rf16_data[$];
   int          rf16_addr[$], rf16_cyc[$], done16_cyc[$];

   always @(posedge clk) begin
      #1;
      if (mem_req) req_cnt++;
      if (rf_wen) begin
         rfw_addr.push_back(int'(rf_waddr));
         rfw_data.push_back(int'(rf_wdata));
         rfw_cyc.push_back(cyc + 1);
      end
      if (mem_req && mem_we && mem_ack) begin
         memw_addr.push_back(int'(mem_addr));
         memw_data.push_back(int'(mem_wdata));
      end
      if (done) done_cyc.push_back(cyc + 1);
      if (prev_wait && mem_req && (mem_addr !== prev_addr || mem_we !== prev_we))
         unstable++;
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      if (rf_wen16) begin
         rf16_addr.push_back(int'(rf_waddr16));
         rf16_data.push_back(rf_wdata16);
         rf16_cyc.push_back(cyc + 1);
      end
      if (done16) done16_cyc.push_back(cyc + 1);
   end

   task automatic clear_logs();
      rfw_addr.delete(); rfw_data.delete(); rfw_cyc.delete();
      memw_addr.delete(); memw_data.delete(); done_cyc.delete();
      rf16_addr.delete(); rf16_data.delete(); rf16_cyc.delete();
      done16_cyc.delete();
      req_cnt = 0;
      unstable = 0;
   endtask

   // Pulse start for one cycle; t is the accepting edge. Afterwards the
   // request fields are scrambled to show they are not re-sampled.
   task automatic do_start(input logic st, input logic [7:0] m,
                           input logic [15:0] b, output int t);
      @(negedge clk);
      is_store  = st;
      mask      = m;
      base_addr = b;
      start     = 1'b1;
      t         = cyc + 1;
      @(negedge clk);
      start     = 1'b0;
      is_store  = ~st;
      mask      = 8'h5A;
      base_addr = 16'h7777;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else passed++;
      total++; if (xfer_count !== 4'd0) $display("FAIL reset_xfer: got %0d expected 0", xfer_count); else passed++;
      total++; if (mem_addr !== 16'h0) $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); else passed++;
      total++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen: got %b expected 0", rf_wen); else passed++;
   endtask

   task automatic test_lm_sparse();
      int t;
      int ea[4] = '{0, 2, 5, 7};
      int ed[4] = '{'hA5E5, 'hA5E4, 'hA5E7, 'hA5E6};
      clear_logs();
      delay_mode = 1'b0;
      do_start(1'b0, 8'b1010_0101, 16'h0040, t);
      wait_done(40);
      total++; if (done_cyc.size() != 1) $display("FAIL lm_done_seen: got %0d pulses expected 1", done_cyc.size()); else passed++;
      total++; if (rfw_addr.size() != 4) $display("FAIL lm_wr_count: got %0d expected 4", rfw_addr.size()); else passed++;
      if (rfw_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (rfw_addr[i] != ea[i] || rfw_data[i] != ed[i] || rfw_cyc[i] != t + 1 + i)
               $display("FAIL lm_write%0d: got r%0d<-%h @%0d expected r%0d<-%h @%0d",
                        i, rfw_addr[i], rfw_data[i], rfw_cyc[i], ea[i], ed[i], t + 1 + i);
            else passed++;
         end
      end
      if (done_cyc.size() > 0) begin
         total++; if (done_cyc[0] != t + 5) $display("FAIL lm_done_cycle: got %0d expected %0d", done_cyc[0], t + 5); else passed++;
      end
      total++; if (xfer_count !== 4'd4) $display("FAIL lm_xfer: got %0d expected 4", xfer_count); else passed++;
      total++; if (memw_addr.size() != 0) $display("FAIL lm_no_mem_we: got %0d writes expected 0", memw_addr.size()); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL lm_idle_after: got busy=%b expected 0", busy); else passed++;
   endtask

   task automatic test_sm_wrap();
      int t;
      int ea[8] = '{'hFFFE, 'hFFFF, 'h0000, 'h0001, 'h0002, 'h0003, 'h0004, 'h0005};
      int ed[8] = '{'h1000, 'h1001, 'h1002, 'h1003, 'h1004, 'h1005, 'h1006, 'h1007};
      clear_logs();
      do_start(1'b1, 8'hFF, 16'hFFFE, t);
      wait_done(40);
      total++; if (memw_addr.size() != 8) $display("FAIL sm_wr_count: got %0d expected 8", memw_addr.size()); else passed++;
      if (memw_addr.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (memw_addr[i] != ea[i] || memw_data[i] != ed[i])
               $display("FAIL sm_write%0d: got M[%h]=%h expected M[%h]=%h",
                        i, memw_addr[i], memw_data[i], ea[i], ed[i]);
            else passed++;
         end
      end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 9)
         $display("FAIL sm_done_cycle: got %0d pulses first@%0d expected 1 @%0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 9);
      else passed++;
      total++; if (rfw_addr.size() != 0) $display("FAIL sm_no_rf_wen: got %0d expected 0", rfw_addr.size()); else passed++;
      total++; if (xfer_count !== 4'd8) $display("FAIL sm_xfer: got %0d expected 8", xfer_count); else passed++;
   endtask

   task automatic test_mask_zero();
      int t;
      clear_logs();
      do_start(1'b0, 8'h00, 16'h1234, t);
      wait_done(10);
      total++; if (req_cnt != 0) $display("FAIL zero_mem_req: got %0d cycles expected 0", req_cnt); else passed++;
      total++; if (rfw_addr.size() != 0) $display("FAIL zero_rf_wen: got %0d expected 0", rfw_addr.size()); else passed++;
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 1)
         $display("FAIL zero_done_cycle: got %0d pulses first@%0d expected 1 @%0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 1);
      else passed++;
      total++; if (xfer_count !== 4'd0) $display("FAIL zero_xfer: got %0d expected 0", xfer_count); else passed++;
   endtask

   task automatic test_wait_states();
      int t;
      clear_logs();
      delay_mode = 1'b1;
      do_start(1'b0, 8'b0000_0011, 16'h0200, t);
      wait_done(40);
      delay_mode = 1'b0;
      total++; if (unstable != 0) $display("FAIL wait_stable: got %0d changes expected 0", unstable); else passed++;
      total++; if (req_cnt != 8) $display("FAIL wait_req_cycles: got %0d expected 8", req_cnt); else passed++;
      total++; if (rfw_addr.size() != 2) $display("FAIL wait_wr_count: got %0d expected 2", rfw_addr.size()); else passed++;
      if (rfw_addr.size() == 2) begin
         total++; if (rfw_addr[0] != 0 || rfw_data[0] != 'hA7A5)
            $display("FAIL wait_write0: got r%0d<-%h expected r0<-a7a5", rfw_addr[0], rfw_data[0]); else passed++;
         total++; if (rfw_addr[1] != 1 || rfw_data[1] != 'hA7A4)
            $display("FAIL wait_write1: got r%0d<-%h expected r1<-a7a4", rfw_addr[1], rfw_data[1]); else passed++;
      end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 9)
         $display("FAIL wait_done_cycle: got %0d pulses first@%0d expected 1 @%0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 9);
      else passed++;
   endtask

   task automatic test_reset_abort();
      int t;
      clear_logs();
      do_start(1'b1, 8'h0F, 16'h0010, t);
      // now in cycle t+1 (first access); move into the second access
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0) $display("FAIL abort_req_gated: got %b expected 0", mem_req); else passed++;
      total++; if (xfer_count !== 4'd1) $display("FAIL abort_pre_xfer: got %0d expected 1", xfer_count); else passed++;
      @(negedge clk);
      reset = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
      total++; if (xfer_count !== 4'd0) $display("FAIL abort_xfer: got %0d expected 0", xfer_count); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL abort_idle_req: got %b expected 0", mem_req); else passed++;
      clear_logs();
      do_start(1'b0, 8'b0000_0110, 16'h0030, t);
      wait_done(20);
      total++; if (rfw_addr.size() != 2) $display("FAIL abort_rerun_count: got %0d expected 2", rfw_addr.size()); else passed++;
      if (rfw_addr.size() == 2) begin
         total++; if (rfw_addr[0] != 1 || rfw_data[0] != 'hA595 || rfw_addr[1] != 2 || rfw_data[1] != 'hA594)
            $display("FAIL abort_rerun_data: got r%0d<-%h r%0d<-%h expected r1<-a595 r2<-a594",
                     rfw_addr[0], rfw_data[0], rfw_addr[1], rfw_data[1]);
         else passed++;
      end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 3)
         $display("FAIL abort_rerun_done: got %0d pulses first@%0d expected 1 @%0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 3);
      else passed++;
   endtask

   task automatic test_ignored();
      int t;
      int ed[4] = '{'hA5F5, 'hA5F4, 'hA5F7, 'hA5F6};
      clear_logs();
      do_start(1'b0, 8'hF0, 16'h0050, t);
      @(negedge clk);
      start = 1'b1; is_store = 1'b1; mask = 8'hFF; base_addr = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      wait_done(20);
      total++; if (rfw_addr.size() != 4) $display("FAIL busy_start_count: got %0d expected 4", rfw_addr.size()); else passed++;
      if (rfw_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (rfw_addr[i] != 4 + i || rfw_data[i] != ed[i])
               $display("FAIL busy_start_write%0d: got r%0d<-%h expected r%0d<-%h",
                        i, rfw_addr[i], rfw_data[i], 4 + i, ed[i]);
            else passed++;
         end
      end
      total++; if (done_cyc.size() != 1 || done_cyc[0] != t + 5)
         $display("FAIL busy_start_done: got %0d pulses first@%0d expected 1 @%0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 5);
      else passed++;
      total++; if (memw_addr.size() != 0) $display("FAIL busy_start_no_store: got %0d expected 0", memw_addr.size()); else passed++;
      // stray ack while idle
      @(negedge clk);
      ack_force = 1'b1;
      #1;
      total++; if (rf_wen !== 1'b0) $display("FAIL idle_ack_rf_wen: got %b expected 0", rf_wen); else passed++;
      @(negedge clk);
      ack_force = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL idle_ack_busy: got %b expected 0", busy); else passed++;
      total++; if (xfer_count !== 4'd4) $display("FAIL idle_ack_xfer: got %0d expected 4", xfer_count); else passed++;
      total++; if (rfw_addr.size() != 4 || done_cyc.size() != 1)
         $display("FAIL idle_ack_activity: got %0d writes %0d dones expected 4 1", rfw_addr.size(), done_cyc.size());
      else passed++;
   endtask

   task automatic test_param_sweep();
      int t;
      clear_logs();
      @(negedge clk);
      mask16 = 16'h8001; base16 = 16'h0100; start16 = 1'b1;
      t = cyc + 1;
      @(negedge clk);
      start16 = 1'b0; mask16 = 16'hFFFF;
      for (int i = 0; i < 20 && done16_cyc.size() == 0; i++) @(negedge clk);
      @(negedge clk);
      total++; if (rf16_addr.size() != 2) $display("FAIL wide_wr_count: got %0d expected 2", rf16_addr.size()); else passed++;
      if (rf16_addr.size() == 2) begin
         total++; if (rf16_addr[0] != 0 || rf16_data[0] !== 32'hC0DE0100 || rf16_cyc[0] != t + 1)
            $display("FAIL wide_write0: got r%0d<-%h @%0d expected r0<-c0de0100 @%0d",
                     rf16_addr[0], rf16_data[0], rf16_cyc[0], t + 1);
         else passed++;
         total++; if (rf16_addr[1] != 15 || rf16_data[1] !== 32'hC0DE0101 || rf16_cyc[1] != t + 2)
            $display("FAIL wide_write1: got r%0d<-%h @%0d expected r15<-c0de0101 @%0d",
                     rf16_addr[1], rf16_data[1], rf16_cyc[1], t + 2);
         else passed++;
      end
      total++; if (done16_cyc.size() != 1 || done16_cyc[0] != t + 3)
         $display("FAIL wide_done: got %0d pulses first@%0d expected 1 @%0d",
                  done16_cyc.size(), (done16_cyc.size() > 0) ? done16_cyc[0] : -1, t + 3);
      else passed++;
      total++; if (xfer16 !== 5'd2) $display("FAIL wide_xfer: got %0d expected 2", xfer16); else passed++;
   endtask

   initial begin
      test_reset();
      test_lm_sparse();
      test_sm_wrap();
      test_mask_zero();
      test_wait_states();
      test_reset_abort();
      test_ignored();
      test_param_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsm_transfer_unit.md
# lsm_transfer_unit

Parametrised load-multiple / store-multiple sequencer for the multicycle RISC core. It replaces the fixed 3-bit counter walk over all eight register slots with a mask-driven engine. The engine skips unselected registers, supports any register-file size and data width, and tolerates variable-latency memory through a req/ack handshake. It sits between the control FSM, the register file and the memory port, and owns those ports for the duration of an LM/SM.

## Interface

Parameters:
- DATA_W, 16, register/memory data width
- ADDR_W, 16, memory word-address width
- NREG, 8, number of architectural registers (mask width)
- REG_AW, $clog2(NREG), register index width
- CNT_W, $clog2(NREG+1), transfer-count width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- is_store  in  1  1 = SM (reg→mem), 0 = LM (mem→reg); sampled with start
- mask  in  NREG  bit i selects register i; sampled with start
- base_addr  in  ADDR_W  first memory word address; sampled with start
- busy  out  1  high from the cycle after accept until the end of DONE
- done  out  1  one-cycle completion pulse
- xfer_count  out  CNT_W  transfers completed in the current/last operation
- rf_raddr  out  REG_AW  register read index (SM)
- rf_rdata  in  DATA_W  combinational register read data for rf_raddr
- rf_waddr  out  REG_AW  register write index (LM)
- rf_wdata  out  DATA_W  register write data (LM)
- rf_wen  out  1  register write strobe (LM)
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write; valid while mem_req
- mem_addr  out  ADDR_W  word address; valid while mem_req
- mem_wdata  out  DATA_W  write data; valid while mem_req and mem_we
- mem_ack  in  1  access complete; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  memory read data

## Operation

- States: IDLE, ACCESS, DONE.
- IDLE: start=1 latches mask→rem_mask, base_addr, is_store; clears xfer_count and offset k. Next state is ACCESS if mask≠0, else DONE.
- ACCESS: idx = lowest set bit of rem_mask (ascending register order).
  - mem_req=1, mem_addr=base+k (modulo 2^ADDR_W, wraps silently), mem_we=is_store.
  - SM: rf_raddr=idx, mem_wdata=rf_rdata.
  - LM: rf_waddr=idx, rf_wdata=mem_rdata; rf_wen=mem_ack (same cycle, combinational).
- On mem_ack in ACCESS: clear bit idx, k+=1, xfer_count+=1. Go to DONE if the cleared rem_mask is 0, else stay in ACCESS with the next idx.
- Without mem_ack, all request outputs hold stable (address, data, we, idx).
- DONE: done=1 for exactly one cycle; busy=1; next state IDLE.
- start while not IDLE is ignored; mask/base/is_store changes after accept have no effect.
- mem_ack while mem_req=0 is ignored.
- Outputs not in use are driven to 0: mem_req, mem_we, rf_wen, done in IDLE; rf_wen during SM; mem_we during LM. Address and data outputs are 0 when idle.
- xfer_count holds its final value after DONE until the next accepted start.

## Timing

- Accept at edge t (start sampled). ACCESS begins cycle t+1, with mem_req high in t+1.
- Zero-wait memory (ack in the same cycle as req): N selected registers take N cycles in ACCESS. done is high in cycle t+1+N. Back-to-back accesses need no idle cycle.
- Each wait cycle (req without ack) adds one cycle.
- mask=0: no memory or RF traffic; done in cycle t+1.
- Next start is accepted in the cycle after done (IDLE).
- Reset: when reset=1 at an edge, the state becomes IDLE and rem_mask, k, xfer_count and all registered outputs become 0.
- mem_req, rf_wen and done are additionally gated low combinationally while reset=1, so an abort never issues a partial write in the reset cycle.
- Reset has priority over start in the same cycle.

## Test plan

- LM, NREG=8, mask=8'b1010_0101, base=0x0040, zero-wait ack → RF writes r0←M[0x40], r2←M[0x41], r5←M[0x42], r7←M[0x43] in 4 consecutive cycles; done at t+5; xfer_count=4.
- SM, mask=8'hFF, base=0xFFFE, r_i=0x1000+i → writes M[0xFFFE]=0x1000, M[0xFFFF]=0x1001, M[0x0000]=0x1002 … M[0x0005]=0x1007 (wrap); done at t+9.
- mask=0 with start → no mem_req, no rf_wen; done pulse at t+1; xfer_count=0.
- LM, mask=8'b0000_0011, ack delayed 3 cycles per access → mem_addr/mem_we stable while waiting; exactly 2 rf_wen pulses; done at t+1+8.
- Reset asserted during the second access of a 4-register SM → that cycle shows mem_req=0; next cycle IDLE, busy=0, xfer_count=0; a following start runs normally.
- start pulsed while busy, and mem_ack pulsed in IDLE → both ignored; no state or count change. Parameter sweep at NREG=16, DATA_W=32 with mask 16'h8001 → r0 then r15.
